// File: rtl/servo_slew_sequencer.sv
// rtl/servo_slew_sequencer.sv - rate-limited servo target sequencer feeding the PWM controller write port
module servo_slew_sequencer #(
  parameter int FRAME_CYCLES = 2000000,
  parameter int DATA_W       = 16,
  parameter int MIN_US       = 500,
  parameter int MAX_US       = 2500,
  parameter int INIT_US      = 1500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] cfg_step,
  input  logic              host_wr,
  input  logic [1:0]        host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ack,
  output logic              cs,
  output logic [1:0]        addr,
  output logic [DATA_W-1:0] data,
  output logic              frame_tick,
  output logic              busy,
  output logic [3:0]        at_target
);

  localparam int CNT_W = $clog2(FRAME_CYCLES);

  typedef enum logic [1:0] {S_INIT_WR, S_IDLE, S_UPDATE, S_WRITE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              tick_q;
  logic [DATA_W-1:0] cur_q [4];
  logic [DATA_W-1:0] tgt_q [4];
  logic              ack_q;
  logic              cs_q, cs_d;
  logic [1:0]        addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              upd_en;
  logic [DATA_W-1:0] host_clamped;
  logic [DATA_W-1:0] slew_val;
  logic [DATA_W:0]   cur_x, tgt_x, step_x, sum_x, dist_x;

  // Clamp incoming host targets into the legal servo range
  always_comb begin
    host_clamped = host_data;
    if (host_data < DATA_W'(MIN_US)) host_clamped = DATA_W'(MIN_US);
    else if (host_data > DATA_W'(MAX_US)) host_clamped = DATA_W'(MAX_US);
  end

  // One slew step for the channel selected by idx; extra bit keeps sums from wrapping
  always_comb begin
    cur_x    = {1'b0, cur_q[idx_q]};
    tgt_x    = {1'b0, tgt_q[idx_q]};
    step_x   = {1'b0, cfg_step};
    sum_x    = cur_x + step_x;
    dist_x   = '0;
    slew_val = cur_q[idx_q];
    if (cfg_step == '0) begin
      slew_val = tgt_q[idx_q];
    end else if (cur_x < tgt_x) begin
      slew_val = (sum_x >= tgt_x) ? tgt_q[idx_q] : sum_x[DATA_W-1:0];
    end else if (cur_x > tgt_x) begin
      dist_x   = cur_x - tgt_x;
      slew_val = (step_x >= dist_x) ? tgt_q[idx_q] : (cur_q[idx_q] - cfg_step);
    end
  end

  // Frame counter: free-runs while enabled, held at zero otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (!enable) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == CNT_W'(FRAME_CYCLES - 1)) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      tick_q <= 1'b0;
    end
  end

  // FSM state and channel index register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT_WR;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: each active state walks idx through all four channels
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_INIT_WR: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = S_IDLE;
      end
      S_IDLE: begin
        idx_d = 2'd0;
        if (tick_q && enable) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  // Output decode: write states drive the controller port, UPDATE advances a channel
  always_comb begin
    cs_d   = 1'b0;
    addr_d = 2'd0;
    data_d = '0;
    upd_en = 1'b0;
    busy   = (state_q != S_IDLE);
    case (state_q)
      S_INIT_WR, S_WRITE: begin
        cs_d   = 1'b1;
        addr_d = idx_q;
        data_d = cur_q[idx_q];
      end
      S_UPDATE: upd_en = 1'b1;
      default: ;
    endcase
  end

  // Registered controller port and host acknowledge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q   <= 1'b0;
      addr_q <= 2'd0;
      data_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      cs_q   <= cs_d;
      addr_q <= addr_d;
      data_q <= data_d;
      ack_q  <= host_wr;
    end
  end

  // Per-channel target and current widths; UPDATE reads the pre-edge target
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cur_q[i] <= DATA_W'(INIT_US);
        tgt_q[i] <= DATA_W'(INIT_US);
      end
    end else begin
      if (host_wr) tgt_q[host_addr] <= host_clamped;
      if (upd_en)  cur_q[idx_q]     <= slew_val;
    end
  end

  // Per-channel arrival flags
  always_comb begin
    for (int i = 0; i < 4; i++) at_target[i] = (cur_q[i] == tgt_q[i]);
  end

  assign host_ack   = ack_q;
  assign cs         = cs_q;
  assign addr       = addr_q;
  assign data       = data_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_servo_slew_sequencer.sv
// tb/tb_servo_slew_sequencer.sv - randomized self-checking bench for servo_slew_sequencer
module tb_servo_slew_sequencer;

  localparam int FC = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] cfg_step = '0;
  logic        host_wr = 1'b0;
  logic [1:0]  host_addr = '0;
  logic [15:0] host_data = '0;
  logic        host_ack, cs, frame_tick, busy;
  logic [1:0]  addr;
  logic [15:0] data;
  logic [3:0]  at_target;

  int total = 0;
  int bad   = 0;
  int cur_m [4];
  int tgt_m [4];
  logic [15:0] got [4];

  servo_slew_sequencer #(.FRAME_CYCLES(FC), .DATA_W(16), .MIN_US(500), .MAX_US(2500), .INIT_US(1500)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_step(cfg_step),
    .host_wr(host_wr), .host_addr(host_addr), .host_data(host_data), .host_ack(host_ack),
    .cs(cs), .addr(addr), .data(data), .frame_tick(frame_tick), .busy(busy), .at_target(at_target)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int clampv(int v);
    if (v < 500) return 500;
    if (v > 2500) return 2500;
    return v;
  endfunction

  // Spec rule: jump on zero step, otherwise move by at most step toward the target
  function automatic int slew(int c, int t, int s);
    if (s == 0) return t;
    if (c < t) return (c + s < t) ? c + s : t;
    if (c > t) return (c - s > t) ? c - s : t;
    return c;
  endfunction

  function automatic logic [3:0] at_m();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (cur_m[i] == tgt_m[i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      cur_m[i] = 1500;
      tgt_m[i] = 1500;
    end
  endtask

  task automatic host_write(int ch, int val);
    host_wr = 1'b1; host_addr = 2'(ch); host_data = 16'(val);
    step();
    host_wr = 1'b0;
    total++;
    if (host_ack !== 1'b1) begin
      $display("FAIL host_ack ch%0d: got %b want 1", ch, host_ack); bad++;
    end
    tgt_m[ch] = clampv(val);
  endtask

  task automatic wait_tick(string name);
    int n = 0;
    while (frame_tick !== 1'b1 && n < 3 * FC) begin step(); n++; end
    total++;
    if (frame_tick !== 1'b1) begin
      $display("FAIL %s tick timeout: got %b want 1", name, frame_tick); bad++;
    end
  endtask

  // Capture the next 4-write burst into got[]
  task automatic get_frame(string name);
    int n = 0;
    while (cs !== 1'b1 && n < 4 * FC) begin step(); n++; end
    total++;
    if (cs !== 1'b1) begin
      $display("FAIL %s write timeout: got cs=%b want 1", name, cs); bad++;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cs !== 1'b1 || addr !== 2'(i)) begin
        $display("FAIL %s burst addr: got cs=%b addr=%0d want cs=1 addr=%0d", name, cs, addr, i); bad++;
      end
      got[i] = data;
      step();
    end
    total++;
    if (cs !== 1'b0 || data !== 16'd0) begin
      $display("FAIL %s after burst: got cs=%b data=%0d want 0 0", name, cs, data); bad++;
    end
  endtask

  task automatic check_frame(string name);
    for (int i = 0; i < 4; i++) cur_m[i] = slew(cur_m[i], tgt_m[i], int'(cfg_step));
    get_frame(name);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got[i] !== 16'(cur_m[i])) begin
        $display("FAIL %s ch%0d data: got %0d want %0d", name, i, got[i], cur_m[i]); bad++;
      end
    end
    total++;
    if (at_target !== at_m()) begin
      $display("FAIL %s at_target: got %b want %b", name, at_target, at_m()); bad++;
    end
  endtask

  // Startup burst of INIT_US on all channels, then idle
  task automatic check_init(string name);
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (cs !== 1'b1 || addr !== 2'(i) || data !== 16'd1500) begin
        $display("FAIL %s init%0d: got cs=%b addr=%0d data=%0d want 1 %0d 1500", name, i, cs, addr, data, i); bad++;
      end
    end
    step();
    total++;
    if (cs !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL %s init end: got cs=%b busy=%b want 0 0", name, cs, busy); bad++;
    end
  endtask

  task automatic test_reset();
    int hits = 0;
    step(); step();
    total++;
    if (cs !== 1'b0 || addr !== 2'd0 || data !== 16'd0 || host_ack !== 1'b0 ||
        frame_tick !== 1'b0 || busy !== 1'b1 || at_target !== 4'hf) begin
      $display("FAIL reset values: got cs=%b addr=%0d data=%0d ack=%b tick=%b busy=%b at=%b want 0 0 0 0 0 1 1111",
               cs, addr, data, host_ack, frame_tick, busy, at_target); bad++;
    end
    rst = 1'b0;
    model_reset();
    check_init("reset");
    for (int i = 0; i < 20; i++) begin
      step();
      if (cs !== 1'b0 || frame_tick !== 1'b0) hits++;
    end
    total++;
    if (hits != 0) begin
      $display("FAIL reset quiet: got %0d active cycles want 0", hits); bad++;
    end
  endtask

  task automatic test_slew();
    int exp0 [6] = '{1600, 1700, 1800, 1900, 2000, 2000};
    cfg_step = 16'd100;
    host_write(0, 2000);
    enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check_frame("slew");
      total++;
      if (got[0] !== 16'(exp0[k]) || at_target[0] !== (k >= 4)) begin
        $display("FAIL slew frame%0d: got data=%0d at=%b want %0d %b", k + 1, got[0], at_target[0], exp0[k], k >= 4); bad++;
      end
    end
  endtask

  task automatic test_tick();
    int n = 0;
    int b = 0;
    int wide = 0;
    wait_tick("tick");
    do begin
      step(); n++;
      if (busy === 1'b1) b++;
      if (n == 1 && frame_tick !== 1'b0) wide++;
    end while (frame_tick !== 1'b1 && n < 3 * FC);
    total++;
    if (n != FC || b != 8 || wide != 0) begin
      $display("FAIL tick period: got period=%0d busy=%0d wide=%0d want %0d 8 0", n, b, wide, FC); bad++;
    end
    check_frame("tick");
  endtask

  task automatic test_clamp();
    cfg_step = 16'd0;
    host_write(1, 3000);
    step();
    total++;
    if (host_ack !== 1'b0) begin
      $display("FAIL ack width: got %b want 0", host_ack); bad++;
    end
    host_write(2, 100);
    host_write(3, 700);
    check_frame("clamp");
    total++;
    if (got[1] !== 16'd2500 || got[2] !== 16'd500 || got[3] !== 16'd700) begin
      $display("FAIL clamp values: got %0d %0d %0d want 2500 500 700", got[1], got[2], got[3]); bad++;
    end
  endtask

  task automatic test_disable();
    int hits = 0;
    wait_tick("disable");
    step();
    enable = 1'b0;
    get_frame("disable");
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got[i] !== 16'(cur_m[i])) begin
        $display("FAIL disable ch%0d: got %0d want %0d", i, got[i], cur_m[i]); bad++;
      end
    end
    for (int i = 0; i < 250; i++) begin
      step();
      if (cs !== 1'b0 || frame_tick !== 1'b0 || busy !== 1'b0) hits++;
    end
    total++;
    if (hits != 0) begin
      $display("FAIL disable quiet: got %0d active cycles want 0", hits); bad++;
    end
    enable = 1'b1;
  endtask

  task automatic test_simul();
    cfg_step = 16'd0;
    for (int i = 0; i < 4; i++) host_write(i, 1500);
    check_frame("simul prep");
    cfg_step = 16'd100;
    wait_tick("simul");
    step(); step();
    host_write(3, 1000);
    host_write(2, 2000);
    cur_m[3] = 1400;
    get_frame("simul");
    total++;
    if (got[0] !== 16'd1500 || got[1] !== 16'd1500 || got[2] !== 16'd1500 || got[3] !== 16'd1400) begin
      $display("FAIL simul frame: got %0d %0d %0d %0d want 1500 1500 1500 1400", got[0], got[1], got[2], got[3]); bad++;
    end
    check_frame("simul next");
    total++;
    if (got[2] !== 16'd1600 || got[3] !== 16'd1300) begin
      $display("FAIL simul next: got %0d %0d want 1600 1300", got[2], got[3]); bad++;
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 10; f++) begin
      int nw = $urandom_range(0, 4);
      int sel = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        int v = ($urandom_range(0, 7) == 0) ? 65535 : $urandom_range(0, 3200);
        host_write($urandom_range(0, 3), v);
      end
      if (sel == 0) cfg_step = 16'd0;
      else if (sel == 1) cfg_step = 16'hffff;
      else cfg_step = 16'($urandom_range(1, 400));
      check_frame("random");
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    cfg_step = 16'd100;
    host_write(1, 2400);
    while (!(cs === 1'b1 && addr === 2'd1) && n < 4 * FC) begin step(); n++; end
    total++;
    if (!(cs === 1'b1 && addr === 2'd1)) begin
      $display("FAIL reset_mid wait: got cs=%b addr=%0d want 1 1", cs, addr); bad++;
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (cs !== 1'b0 || data !== 16'd0 || busy !== 1'b1) begin
      $display("FAIL reset_mid abort: got cs=%b data=%0d busy=%b want 0 0 1", cs, data, busy); bad++;
    end
    step(); step();
    rst = 1'b0;
    model_reset();
    check_init("reset_mid");
    total++;
    if (at_target !== 4'hf) begin
      $display("FAIL reset_mid at_target: got %b want 1111", at_target); bad++;
    end
    check_frame("reset_mid frame");
  endtask

  initial begin
    test_reset();
    test_slew();
    test_tick();
    test_clamp();
    test_disable();
    test_simul();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
